// File: rtl/noc_input_buffer.sv
// noc_input_buffer: credit-based input port buffer for one NoC router port.
// Flits from the upstream link are stored in a DEPTH-entry first-word-fall-through FIFO.
// A packet FSM walks header, size and payload flits. It raises a routing request (h)
// while a header waits at the head, and forwards flits downstream once routing is granted.
//
// Ports:
//   clk       clock; all state updates on posedge
//   rst       synchronous active-low reset
//   rx        upstream flit valid
//   data_in   upstream flit
//   credit_o  space available; upstream may send only while high
//   tx        downstream flit valid
//   data_out  FIFO head flit (undefined while count == 0)
//   credit_i  downstream accepts a flit this cycle
//   h         routing request; header flit is at the FIFO head
//   ack_h     routing granted for the pending header
//   count     FIFO occupancy, 0..DEPTH
//   overflow  sticky error: rx seen while credit_o was low
module noc_input_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [DATA_W-1:0] data_in,
  output logic              credit_o,
  output logic              tx,
  output logic [DATA_W-1:0] data_out,
  input  logic              credit_i,
  output logic              h,
  input  logic              ack_h,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StHdr, StSize, StPayload} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   remaining_q, remaining_d;
  logic                overflow_q;
  logic                h_q, tx_q;
  logic                wr_en, rd_en;

  // credit_o is low during reset, so no write can slip in while rst is asserted.
  assign credit_o = rst && (count_q != CNT_W'(DEPTH));
  assign wr_en    = rx && credit_o;
  assign rd_en    = tx_q && credit_i;
  assign data_out = mem_q[rd_ptr_q];

  assign tx       = tx_q;
  assign h        = h_q;
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (ack_h && h_q) state_d = StHdr;
      end
      StHdr: begin
        if (rd_en) state_d = StSize;
      end
      StSize: begin
        if (rd_en) begin
          remaining_d = data_out;
          state_d     = (data_out == '0) ? StIdle : StPayload;
        end
      end
      StPayload: begin
        if (rd_en) begin
          remaining_d = remaining_q - DATA_W'(1);
          if (remaining_q == DATA_W'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage has no reset; only the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
      h_q         <= 1'b0;
      tx_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (rx && !credit_o) overflow_q <= 1'b1;
      // Registered from next state so h/tx track state and occupancy of the coming cycle.
      h_q  <= (state_d == StIdle) && (count_d != '0);
      tx_q <= (state_d != StIdle) && (count_d != '0);
    end
  end

endmodule
